// File: rtl/psram_pkg.sv
// psram_pkg: shared constants for the PSRAM port arbiter and related blocks.
//   PSRAM_AW / PSRAM_DW : controller byte-address and data-word widths
//   ST_*                : arbiter FSM state encoding
package psram_pkg;

  localparam int PSRAM_AW = 22;
  localparam int PSRAM_DW = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/psram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_req   : request vector, one bit per requester
//   i_last  : index of the most recent grant
//   o_valid : at least one request is set
//   o_idx   : first set request scanning upward from i_last+1, wrapping at NPORTS
module rr_pick #(
  parameter int NPORTS = 3
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [2:0]        i_last,
  output logic              o_valid,
  output logic [2:0]        o_idx
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [IW-1:0] w_cand;

  // Walk the offsets from farthest to nearest so the nearest set bit after
  // i_last is the last one written and therefore wins.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = NPORTS; i >= 1; i--) begin
      w_cand = IW'((int'(i_last) + i) % NPORTS);
      if (i_req[w_cand]) begin
        o_idx = 3'(w_cand);
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin sharing of one PsramController port among NPORTS requesters.
//   i_clk, i_reset          : controller clock, synchronous active-high reset
//   i_req/i_we/i_addr/...   : per-port request bundle, held until o_ack
//   o_ack, o_done           : per-port one-cycle accept / completion pulses
//   o_rdata                 : last completed read word, shared by all ports
//   o_timeout_err           : sticky, busy never rose after a strobe
//   o_ctl_* / i_ctl_*       : PsramController word/byte interface
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int NPORTS  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NPORTS-1:0]        i_req,
  input  logic [NPORTS-1:0]        i_we,
  input  logic [NPORTS*PSRAM_AW-1:0] i_addr,
  input  logic [NPORTS*PSRAM_DW-1:0] i_wdata,
  input  logic [NPORTS-1:0]        i_byte_write,
  output logic [NPORTS-1:0]        o_ack,
  output logic [NPORTS-1:0]        o_done,
  output logic [PSRAM_DW-1:0]      o_rdata,
  output logic                     o_timeout_err,
  output logic                     o_ctl_read,
  output logic                     o_ctl_write,
  output logic [PSRAM_AW-1:0]      o_ctl_addr,
  output logic [PSRAM_DW-1:0]      o_ctl_din,
  output logic                     o_ctl_byte_write,
  input  logic [PSRAM_DW-1:0]      i_ctl_dout,
  input  logic                     i_ctl_busy
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]          r_state;
  logic [2:0]          r_last;
  logic [IW-1:0]       r_owner;
  logic                r_is_read;
  logic [TW-1:0]       r_timer;
  logic [NPORTS-1:0]   r_ack;
  logic [NPORTS-1:0]   r_done;
  logic [PSRAM_DW-1:0] r_rdata;
  logic                r_timeout_err;
  logic                r_ctl_read;
  logic                r_ctl_write;
  logic [PSRAM_AW-1:0] r_ctl_addr;
  logic [PSRAM_DW-1:0] r_ctl_din;
  logic                r_ctl_byte_write;

  logic                w_valid;
  logic [2:0]          w_idx;
  logic [IW-1:0]       w_sel;
  logic [PSRAM_AW-1:0] w_addr  [NPORTS];
  logic [PSRAM_DW-1:0] w_wdata [NPORTS];

  rr_pick #(
    .NPORTS(NPORTS)
  ) u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_valid(w_valid),
    .o_idx  (w_idx)
  );

  assign w_sel = w_idx[IW-1:0];

  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      w_addr[k]  = i_addr[k*PSRAM_AW +: PSRAM_AW];
      w_wdata[k] = i_wdata[k*PSRAM_DW +: PSRAM_DW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= ST_IDLE;
      r_last           <= 3'(NPORTS - 1);
      r_owner          <= '0;
      r_is_read        <= 1'b0;
      r_timer          <= '0;
      r_ack            <= '0;
      r_done           <= '0;
      r_rdata          <= '0;
      r_timeout_err    <= 1'b0;
      r_ctl_read       <= 1'b0;
      r_ctl_write      <= 1'b0;
      r_ctl_addr       <= '0;
      r_ctl_din        <= '0;
      r_ctl_byte_write <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          // Busy high also covers controller init, so nothing is granted then.
          if (!i_ctl_busy && w_valid) begin
            r_ctl_addr       <= w_addr[w_sel];
            r_ctl_din        <= w_wdata[w_sel];
            r_ctl_byte_write <= i_byte_write[w_sel];
            r_ctl_write      <= i_we[w_sel];
            r_ctl_read       <= ~i_we[w_sel];
            r_is_read        <= ~i_we[w_sel];
            r_ack[w_sel]     <= 1'b1;
            r_last           <= w_idx;
            r_owner          <= w_sel;
            r_state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Strobe is a single cycle; address/data stay put until the next grant.
          r_ctl_read  <= 1'b0;
          r_ctl_write <= 1'b0;
          r_timer     <= '0;
          r_state     <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (i_ctl_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_timer == TW'(TIMEOUT)) begin
            // Release the owner anyway so a dead controller cannot hang requesters.
            r_timeout_err  <= 1'b1;
            r_done[r_owner] <= 1'b1;
            r_state        <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!i_ctl_busy) begin
            if (r_is_read) begin
              r_rdata <= i_ctl_dout;
            end
            r_done[r_owner] <= 1'b1;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ack            = r_ack;
  assign o_done           = r_done;
  assign o_rdata          = r_rdata;
  assign o_timeout_err    = r_timeout_err;
  assign o_ctl_read       = r_ctl_read;
  assign o_ctl_write      = r_ctl_write;
  assign o_ctl_addr       = r_ctl_addr;
  assign o_ctl_din        = r_ctl_din;
  assign o_ctl_byte_write = r_ctl_byte_write;

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Round-robin arbiter that shares one PsramController word/byte port between NPORTS requesters (e.g. CPU, video fetch, DMA).
- Each requester holds a request until it is accepted. The arbiter drives one single-cycle read/write strobe into the controller, then tracks its busy flag to completion.
- On completion it returns read data and a per-port done pulse.
- Sits between the requester logic and PsramController, in the controller's clk domain.

Parameters:
- NPORTS, 3, number of requesters (2..8)
- TIMEOUT, 64, maximum cycles to wait for controller busy to rise after a strobe before flagging an error

Ports:
- clk  in  1  system clock, same clock as PsramController
- reset  in  1  synchronous, active-high reset
- req  in  NPORTS  per-port request, held high until ack
- we  in  NPORTS  per-port 1=write, 0=read; qualified by req
- addr  in  NPORTS*22  per-port byte address; port k occupies [22k+21:22k]
- wdata  in  NPORTS*16  per-port write word
- byte_write  in  NPORTS  per-port byte-write select (addr[0] selects the half)
- ack  out  NPORTS  one-cycle pulse: request accepted; requester may drop or change req the next cycle
- done  out  NPORTS  one-cycle pulse: operation complete; rdata valid this cycle for reads
- rdata  out  16  read word, shared by all ports; holds its value until the next read completes
- timeout_err  out  1  sticky flag, set when busy fails to rise within TIMEOUT; cleared only by reset
- ctl_read  out  1  to controller read
- ctl_write  out  1  to controller write
- ctl_addr  out  22  to controller addr
- ctl_din  out  16  to controller din
- ctl_byte_write  out  1  to controller byte_write
- ctl_dout  in  16  from controller dout
- ctl_busy  in  1  from controller busy; high during controller init and while an operation runs

Behaviour:
- Reset values: ack=0, done=0, rdata=0, timeout_err=0, ctl_read=0, ctl_write=0, ctl_addr=0, ctl_din=0, ctl_byte_write=0, state=IDLE, last_grant=NPORTS-1 (port 0 wins first).
- IDLE state:
  - Acts when ctl_busy=0 and any req bit is set. Otherwise it stays in IDLE, which covers the whole controller init period.
  - Selects the winner by round-robin: the first set req bit scanning upward from last_grant+1, wrapping modulo NPORTS.
  - Registers the winner's addr, wdata and byte_write into the ctl_* outputs, and sets ctl_write=we[k] or ctl_read=~we[k].
  - Pulses ack[k], sets last_grant=k, latches the owner index, and moves to ISSUE.
- ISSUE state, 1 cycle:
  - The strobe is visible to the controller in this cycle.
  - Next cycle: strobe deasserted, timer cleared, go to WAIT_BUSY.
- WAIT_BUSY state:
  - ctl_busy=1 moves to WAIT_DONE.
  - Otherwise the timer increments. If the timer reaches TIMEOUT: set timeout_err, pulse done[owner] with rdata unchanged, return to IDLE.
- WAIT_DONE state:
  - Waits for ctl_busy=0. In that same cycle ctl_dout is valid.
  - For a read, capture rdata<=ctl_dout. In both cases pulse done[owner] the next cycle and go to IDLE.
- ctl_addr, ctl_din and ctl_byte_write are held stable from ISSUE until the next grant. The controller latches din only at its start; the hold is for safety.
- At most one operation is outstanding. ack and done never fire for two ports in the same cycle.
- The cycle done pulses, the arbiter is in IDLE and may grant again that same cycle, provided ctl_busy=0.
- Nominal latency, req-sampled to done: 1 (grant) + 1 (ISSUE) + controller operation + 1. For a read this is about 15/18 cycles at 1x/2x latency.
- Fairness: a port with req held is granted within NPORTS grants.
- A requester must not drop req before ack. If it does, the request is simply not seen; no error is raised.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values and no done pulse. The controller resetn is driven externally from the same reset.

Decomposition:
- Shared package psram_pkg:
  - state encoding localparams ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE
  - PSRAM_AW=22, PSRAM_DW=16
- One natural sub-module: rr_pick.
  - Combinational round-robin picker: inputs req[NPORTS-1:0] and last[2:0]; outputs valid and idx[2:0].
  - Reusable by other shared-resource blocks.

Test Plan:
- Single read: ctl_busy=0, port 1 read, addr=22'h000124; controller model returns 16'hBEEF after 12 busy cycles -> ack[1] pulses at cycle 1, ctl_read high exactly 1 cycle, done[1] pulses with rdata=16'hBEEF, no other ack/done bits set.
- Simultaneous requests: ports 0, 1 and 2 all assert req at the same time after reset -> grants in order 0,1,2. Re-asserting all three -> order 0,1,2 again. If only 0 and 2 re-assert -> order 0,2.
- Hog: port 0 holds req continuously while port 2 asserts once -> port 2 granted at the second grant after its assertion, never later.
- Init hold-off: ctl_busy=1 for 200 cycles with port 0 req high -> no ack and no strobe until the cycle after ctl_busy falls.
- Byte write: port 2 write, addr=22'h00_0003, wdata=16'hA55A, byte_write=1 -> ctl_write=1, ctl_byte_write=1, ctl_addr=22'h000003, ctl_din=16'hA55A for one cycle; done[2] follows; rdata unchanged.
- Fault and reset: controller model never raises busy -> timeout_err=1 and done pulses TIMEOUT+2 cycles after ack. Reset asserted during WAIT_DONE -> no done pulse, all outputs at reset values, next grant goes to port 0.
